// File: rtl/stride_detector.sv
// ---------------------------------------------------------------------------
// stride_detector
//
// Upstream stage of the prefetcher controller. Watches accepted AXI read
// address requests and learns a constant address stride for a single
// transaction ID inside the inclusive window [bar, limit]. Once the
// confidence counter reaches the lock threshold, the locked stride and the
// predicted next address are presented to the controller. Leaving LOCKED for
// any reason other than flush produces a one-cycle stride_break pulse.
//
// Optional feature (compile-time macro STRIDE_DET_LEN_MATCH_EN):
//   When defined, the burst length becomes part of the pattern. A change of
//   ar_len in TRAIN/LOCKED is handled as a stride mismatch. When undefined,
//   ar_len is not used and no ctx_len register is built.
//
// Ports:
//   clk            clock
//   resetN         synchronous active-low reset
//   flush          drop the learned context and return to IDLE
//   ar_valid       snooped AR valid
//   ar_ready       snooped AR ready (handshake = ar_valid & ar_ready)
//   ar_addr        request address
//   ar_id          request ID
//   ar_len         burst length (used only with STRIDE_DET_LEN_MATCH_EN)
//   bar            window base, inclusive
//   limit          window top, inclusive
//   conf_thresh    confidence needed to lock (0 behaves as 1)
//   ctx_valid      a context ID has been captured
//   ctx_id         captured ID
//   stride_locked  stride is trusted
//   stride         learned stride, two's complement bytes
//   next_addr      last_addr + stride while locked, else 0
//   stride_break   one-cycle pulse on leaving LOCKED due to a mismatch
// ---------------------------------------------------------------------------
module stride_detector #(
    parameter int ADDR_BITS       = 64,
    parameter int TID_WIDTH       = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int STRIDE_WIDTH    = 16,
    parameter int CONF_WIDTH      = 3
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       flush,
    input  logic                       ar_valid,
    input  logic                       ar_ready,
    input  logic [ADDR_BITS-1:0]       ar_addr,
    input  logic [TID_WIDTH-1:0]       ar_id,
    input  logic [BURST_LEN_WIDTH-1:0] ar_len,
    input  logic [ADDR_BITS-1:0]       bar,
    input  logic [ADDR_BITS-1:0]       limit,
    input  logic [CONF_WIDTH-1:0]      conf_thresh,
    output logic                       ctx_valid,
    output logic [TID_WIDTH-1:0]       ctx_id,
    output logic                       stride_locked,
    output logic [STRIDE_WIDTH-1:0]    stride,
    output logic [ADDR_BITS-1:0]       next_addr,
    output logic                       stride_break
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_TRAIN  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t                    state_reg, state_next;
    logic                      ctx_valid_reg, ctx_valid_next;
    logic [TID_WIDTH-1:0]      ctx_id_reg, ctx_id_next;
    logic [ADDR_BITS-1:0]      last_addr_reg, last_addr_next;
    logic [STRIDE_WIDTH-1:0]   stride_reg, stride_next;
    logic [CONF_WIDTH-1:0]     conf_reg, conf_next;
    logic                      locked_reg, locked_next;
    logic [ADDR_BITS-1:0]      next_addr_reg, next_addr_next;
    logic                      break_reg, break_next;

    // Event qualification
    logic                      handshake;
    logic                      in_window;
    logic                      id_ok;
    logic                      evt;

    // Delta evaluation
    logic [ADDR_BITS-1:0]      delta;
    logic [STRIDE_WIDTH-1:0]   delta_s;
    logic                      delta_fits;
    logic                      delta_zero;
    logic                      stride_match;
    logic                      len_ok;
    logic [CONF_WIDTH-1:0]     thr_eff;
    logic [CONF_WIDTH-1:0]     conf_inc;

`ifdef STRIDE_DET_LEN_MATCH_EN
    logic [BURST_LEN_WIDTH-1:0] ctx_len_reg, ctx_len_next;
`else
    // Burst length does not take part in the pattern in this build.
    logic unused_ar_len;
    assign unused_ar_len = ^ar_len;
`endif

    assign handshake = ar_valid & ar_ready;
    // Unsigned, inclusive; bar > limit can never be satisfied.
    assign in_window = (ar_addr >= bar) && (ar_addr <= limit);
    assign id_ok     = !ctx_valid_reg || (ar_id == ctx_id_reg);
    assign evt       = handshake && in_window && id_ok;

    assign delta   = ar_addr - last_addr_reg;
    assign delta_s = delta[STRIDE_WIDTH-1:0];
    // Representable as a signed STRIDE_WIDTH value when every bit from the
    // stride sign bit upward is identical.
    assign delta_fits = (&delta[ADDR_BITS-1:STRIDE_WIDTH-1]) ||
                        (~|delta[ADDR_BITS-1:STRIDE_WIDTH-1]);
    assign delta_zero   = (delta == '0);
    assign stride_match = delta_fits && (delta_s == stride_reg);

`ifdef STRIDE_DET_LEN_MATCH_EN
    assign len_ok = (ar_len == ctx_len_reg);
`else
    assign len_ok = 1'b1;
`endif

    assign thr_eff  = (conf_thresh == '0) ? CONF_WIDTH'(1) : conf_thresh;
    assign conf_inc = (&conf_reg) ? conf_reg : conf_reg + CONF_WIDTH'(1);

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ctx_valid_next = ctx_valid_reg;
        ctx_id_next    = ctx_id_reg;
        last_addr_next = last_addr_reg;
        stride_next    = stride_reg;
        conf_next      = conf_reg;
        break_next     = 1'b0;
`ifdef STRIDE_DET_LEN_MATCH_EN
        ctx_len_next   = ctx_len_reg;
`endif

        if (flush) begin
            // Flush wins over a coincident event and never signals a break.
            state_next     = S_IDLE;
            ctx_valid_next = 1'b0;
            ctx_id_next    = '0;
            last_addr_next = '0;
            stride_next    = '0;
            conf_next      = '0;
`ifdef STRIDE_DET_LEN_MATCH_EN
            ctx_len_next   = '0;
`endif
        end else if (evt && (state_reg == S_IDLE || !delta_zero)) begin
            // A repeated address carries no stride information. In IDLE there
            // is no meaningful previous address, so the first capture is
            // always taken.
            unique case (state_reg)
                S_IDLE: begin
                    ctx_valid_next = 1'b1;
                    ctx_id_next    = ar_id;
                    last_addr_next = ar_addr;
`ifdef STRIDE_DET_LEN_MATCH_EN
                    ctx_len_next   = ar_len;
`endif
                    state_next     = S_FIRST;
                end
                S_FIRST: begin
                    last_addr_next = ar_addr;
`ifdef STRIDE_DET_LEN_MATCH_EN
                    ctx_len_next   = ar_len;
`endif
                    if (delta_fits) begin
                        stride_next = delta_s;
                        conf_next   = CONF_WIDTH'(1);
                        state_next  = S_TRAIN;
                    end
                end
                S_TRAIN: begin
                    last_addr_next = ar_addr;
`ifdef STRIDE_DET_LEN_MATCH_EN
                    ctx_len_next   = ar_len;
`endif
                    if (stride_match && len_ok) begin
                        conf_next = conf_inc;
                        if (conf_inc >= thr_eff) begin
                            state_next = S_LOCKED;
                        end
                    end else begin
                        conf_next = CONF_WIDTH'(1);
                        if (delta_fits) begin
                            stride_next = delta_s;
                        end else begin
                            state_next = S_FIRST;
                        end
                    end
                end
                S_LOCKED: begin
                    last_addr_next = ar_addr;
`ifdef STRIDE_DET_LEN_MATCH_EN
                    ctx_len_next   = ar_len;
`endif
                    if (stride_match && len_ok) begin
                        conf_next = conf_inc;
                    end else begin
                        break_next = 1'b1;
                        conf_next  = '0;
                        if (delta_fits) begin
                            stride_next = delta_s;
                            state_next  = S_TRAIN;
                        end else begin
                            state_next  = S_FIRST;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        // Prediction is produced from the post-update context so it is
        // coherent with stride/stride_locked in the same cycle.
        locked_next    = (state_next == S_LOCKED);
        next_addr_next = locked_next
                       ? last_addr_next + {{(ADDR_BITS-STRIDE_WIDTH){stride_next[STRIDE_WIDTH-1]}},
                                           stride_next}
                       : '0;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg     <= S_IDLE;
            ctx_valid_reg <= 1'b0;
            ctx_id_reg    <= '0;
            last_addr_reg <= '0;
            stride_reg    <= '0;
            conf_reg      <= '0;
            locked_reg    <= 1'b0;
            next_addr_reg <= '0;
            break_reg     <= 1'b0;
`ifdef STRIDE_DET_LEN_MATCH_EN
            ctx_len_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            ctx_valid_reg <= ctx_valid_next;
            ctx_id_reg    <= ctx_id_next;
            last_addr_reg <= last_addr_next;
            stride_reg    <= stride_next;
            conf_reg      <= conf_next;
            locked_reg    <= locked_next;
            next_addr_reg <= next_addr_next;
            break_reg     <= break_next;
`ifdef STRIDE_DET_LEN_MATCH_EN
            ctx_len_reg   <= ctx_len_next;
`endif
        end
    end

    assign ctx_valid     = ctx_valid_reg;
    assign ctx_id        = ctx_id_reg;
    assign stride_locked = locked_reg;
    assign stride        = stride_reg;
    assign next_addr     = next_addr_reg;
    assign stride_break  = break_reg;

endmodule
